fc_result_pack_array: RTL
=========================

# fc_result_pack_array

Parallel-to-packet transmitter for fully-connected layer results. It captures a full RL-element result vector in one cycle from the accumulator array. It then streams the vector to the write_op module as DW-bit packets, using a valid/ready handshake. Packet order and lane layout match the team's bias/weight register-array receive format, so a receiver built on the same convention rebuilds the vector unchanged.

## Interface
- FW, 32: float width, bits per element
- DW, 512: packet width toward write_op
- RL, 512: elements per result vector
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- load_i  input  1  capture request for data_i
- data_i  input  RL*FW  result vector; element e at bits [(e+1)*FW-1 : e*FW]
- busy_o  output  1  high while a vector is held or being sent
- data_o  output  DW  current packet
- valid_o  output  1  data_o is valid
- ready_i  input  1  write_op accepts the packet this cycle
- last_o  output  1  data_o is the final packet of the vector
- done_o  output  1  one-cycle pulse after the final packet is accepted

## Operation
- Derived constants:
  - PACKAGE_LEN = DW/FW
  - PACKAGE_NUM = RL/PACKAGE_LEN
  - CW = max(1, clog2(PACKAGE_NUM))
  - Required: DW%FW==0 and RL%PACKAGE_LEN==0. Elaboration fails otherwise.
- Storage: shadow register of RL*FW bits, plus beat counter cnt of CW bits.
- FSM states:
  - IDLE: busy_o=0, valid_o=0. load_i=1 captures data_i into the shadow, sets cnt=0 and moves to SEND.
  - SEND: busy_o=1, valid_o=1. A handshake (valid_o && ready_i) increments cnt.
  - On the handshake with cnt==PACKAGE_NUM-1, the FSM returns to IDLE and done_o pulses on the next cycle.
- Packet content: beat k carries package p = PACKAGE_NUM-1-k, i.e. descending package order.
  - Lane j of data_o ([(j+1)*FW-1 : j*FW]) = element p*PACKAGE_LEN + j.
- last_o = valid_o && (cnt==PACKAGE_NUM-1).
- load_i while in SEND is ignored, except on the final-handshake cycle.
  - There it is accepted: new capture, cnt=0, FSM stays in SEND, done_o still pulses next cycle.
  - This allows back-to-back vectors with no bubble.
- Reset (asynchronous, any time, including mid-transfer):
  - State IDLE, cnt=0, shadow=0.
  - data_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0.
  - An aborted vector produces no done_o.

## Timing
- Latency: load_i sampled high at edge t gives valid_o=1 with beat 0 from edge t onward (registered outputs).
- data_o and last_o are registered. While valid_o && !ready_i they hold stable; no element changes.
- With ready_i tied high, one vector takes exactly PACKAGE_NUM cycles with valid_o high.
- done_o is registered and high for exactly one cycle, the cycle after the final handshake.
- PACKAGE_NUM==1: a single beat with last_o=1. done_o follows the handshake.
- Changes to data_i after the capture edge do not affect packets in flight.
- ready_i while valid_o=0 has no effect.

## Structure
- The shared constants package holds the FW/DW/RL defaults and the PACKAGE_LEN/PACKAGE_NUM/CW derivations. The matching receive arrays use the same package.
- FSM state encoding (IDLE=0, SEND=1) is a localparam pair in the same package.
- Packet selection uses an indexed part-select of the shadow: base (PACKAGE_NUM-1-cnt)*DW. The shadow is not shifted.
- No sub-module is needed. The block stays flat.

## Test plan
- Default params, data_i element e = e, ready_i=1, load_i pulse:
  - 32 beats; beat 0 lane 0 = 496, lane 15 = 511; beat 31 lane 0 = 0.
  - last_o only on beat 31; done_o high one cycle after it.
- Backpressure: ready_i low for 5 cycles at beat 3 -> data_o and valid_o held constant; beat 4 appears only after ready_i rises; total beats still 32.
- Back-to-back: second load_i (element e = e+1000) asserted on the beat-31 handshake -> next cycle shows beat 0 of the new vector (lane 0 = 1496) with valid_o held high; done_o pulses once for the first vector.
- Loads at beat 10 are ignored; data_i changed after capture -> transmitted packets match the original capture.
- rst_i pulsed at beat 12 -> all outputs 0 immediately and no done_o; a fresh load_i then restarts at beat 0.
- FW=16, DW=32, RL=2 (PACKAGE_NUM=1) -> a single beat with valid_o and last_o together; lane 0 = element 0; done_o follows.

Source files
------------

// File: rtl/fc_result_pack_array_pkg.sv
// Shared constants for the fully-connected result transmit and receive arrays.
// This package holds the default element, packet and vector sizes, the
// helpers that derive the packet geometry, and the transmitter state type.
package fc_result_pack_array_pkg;

  localparam int unsigned FC_FW = 32;   // bits per element
  localparam int unsigned FC_DW = 512;  // packet width
  localparam int unsigned FC_RL = 512;  // elements per result vector

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Elements carried by one packet.
  function automatic int unsigned pkg_len(input int unsigned dw, input int unsigned fw);
    return (fw == 0) ? 0 : dw / fw;
  endfunction

  // Packets needed for one vector.
  function automatic int unsigned pkg_num(input int unsigned rl, input int unsigned dw,
                                          input int unsigned fw);
    int unsigned len;
    len = pkg_len(dw, fw);
    return (len == 0) ? 0 : rl / len;
  endfunction

  // Beat counter width. It is never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc_result_pack_array.sv
// fc_result_pack_array: captures an RL-element result vector in one cycle.
// It then streams the vector as DW-bit packets over a valid/ready handshake.
// Packets go out in descending package order. Lane j of each packet holds
// element p*PACKAGE_LEN + j.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   load_i   capture request for data_i
//   data_i   result vector, element e at [(e+1)*FW-1 : e*FW]
//   busy_o   a vector is held or being sent
//   data_o   current packet (registered)
//   valid_o  data_o is valid
//   ready_i  receiver accepts the packet this cycle
//   last_o   data_o is the final packet of the vector (registered)
//   done_o   one-cycle pulse after the final packet is accepted
module fc_result_pack_array
  import fc_result_pack_array_pkg::*;
#(
  parameter int unsigned FW = FC_FW,
  parameter int unsigned DW = FC_DW,
  parameter int unsigned RL = FC_RL
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [RL*FW-1:0] data_i,
  output logic            busy_o,
  output logic [DW-1:0]   data_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            last_o,
  output logic            done_o
);

  localparam int unsigned PACKAGE_LEN = pkg_len(DW, FW);
  localparam int unsigned PACKAGE_NUM = pkg_num(RL, DW, FW);
  localparam int unsigned CW          = cnt_width(PACKAGE_NUM);
  localparam int unsigned SW          = $clog2(RL * FW);
  localparam logic [CW-1:0] LAST_CNT  = CW'(PACKAGE_NUM - 1);

  if ((FW == 0) || (PACKAGE_LEN == 0) || ((DW % FW) != 0) || ((RL % PACKAGE_LEN) != 0))
  begin : g_bad_geometry
    $error("fc_result_pack_array: DW must be a multiple of FW and RL a multiple of DW/FW");
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RL*FW-1:0]    shadow_q, shadow_d;
  logic [DW-1:0]       data_q, data_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  logic                handshake;
  logic                final_beat;
  logic                capture;
  logic [CW-1:0]       pkg_idx;
  logic [SW-1:0]       sel_base;

  always_comb begin
    handshake  = (state_q == ST_SEND) && ready_i;
    final_beat = handshake && (cnt_q == LAST_CNT);

    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = final_beat;
    capture  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_i) capture = 1'b1;
      end
      ST_SEND: begin
        if (final_beat) begin
          // A load on the final handshake chains the next vector without a bubble.
          if (load_i) begin
            capture = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (handshake) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      shadow_d = data_i;
      cnt_d    = '0;
      state_d  = ST_SEND;
    end

    // The registered packet is selected from the next-cycle shadow and beat.
    // This lets beat 0 appear on the same edge that captures the vector.
    pkg_idx  = LAST_CNT - cnt_d;
    sel_base = SW'(pkg_idx * DW);
    data_d   = shadow_d[sel_base +: DW];
    last_d   = (state_d == ST_SEND) && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign busy_o  = (state_q == ST_SEND);
  assign valid_o = (state_q == ST_SEND);
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign done_o  = done_q;

endmodule
